// File: rtl/adder_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_arbiter_pkg
//  Purpose  : Shared types, constants and helpers for the adder arbiter.
//             Holds the FSM state encoding, the default adder slice width,
//             the requester-id width helper and the signed-overflow rule.
//  Revision : 1.0  initial release
// ============================================================================
package adder_arbiter_pkg;

    // Sequencer states: one pass for narrow ops, two passes for wide ops.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Default slice width of the shared adder.
    localparam int c_adder_w = 32;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Two's-complement overflow: both adder inputs share a sign and the
    // sum's sign differs from it. The B input is the already-inverted
    // operand for subtracts.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_arbiter_fulladder32.sv
`default_nettype none
// ============================================================================
//  Module   : fulladder32
//  Purpose  : Shared W-bit ripple/behavioural adder with carry in and out.
//  Ports    : a, b    in  W  addends
//             cin     in  1  carry in
//             s       out W  sum
//             cout    out 1  carry out of bit W-1
//  Revision : 1.0  initial release
// ============================================================================
module fulladder32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : adder_arbiter
//  Purpose  : Shares one W-bit adder among NREQ requesters with round-robin
//             arbitration. Narrow ops take one adder pass, wide (2W) ops take
//             two passes with the carry chained through a register.
//             Subtract is performed as A + ~B + 1.
//  Ports    : clk        in   1          rising-edge clock
//             rst        in   1          asynchronous active-high reset
//             req_valid  in   NREQ       request valid, held until accepted
//             req_ready  out  NREQ       request accepted this cycle
//             req_a      in   NREQ*2W    operand A, requester i at [i*2W +: 2W]
//             req_b      in   NREQ*2W    operand B, same packing
//             req_sub    in   NREQ       1 = A-B, 0 = A+B
//             req_wide   in   NREQ       1 = 2W-bit op, 0 = W-bit op
//             rsp_valid  out  1          result valid, held until rsp_ready
//             rsp_ready  in   1          consumer takes result
//             rsp_id     out  ID_W       requester that owns the result
//             rsp_s      out  2W         sum, upper W zero for narrow ops
//             rsp_cout   out  1          carry out of the op MSB
//             rsp_ovf    out  1          signed overflow at the op MSB
//  Revision : 1.0  initial release
// ============================================================================
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = c_adder_w,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*2*W-1:0]  req_a,
    input  logic [NREQ*2*W-1:0]  req_b,
    input  logic [NREQ-1:0]      req_sub,
    input  logic [NREQ-1:0]      req_wide,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [2*W-1:0]       rsp_s,
    output logic                 rsp_cout,
    output logic                 rsp_ovf
);

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_gnt;
    logic [2*W-1:0]     r_a;
    logic [2*W-1:0]     r_b;        // already inverted for subtracts
    logic               r_sub;
    logic               r_wide;
    logic [W-1:0]       r_s_lo;
    logic               r_c_lo;

    logic [2*W-1:0]     w_a_arr  [NREQ];
    logic [2*W-1:0]     w_b_arr  [NREQ];
    logic [ID_W-1:0]    w_cand   [NREQ];
    logic [ID_W-1:0]    w_gnt;
    logic               w_found;
    logic               w_accept;
    logic               w_hi;
    logic [W-1:0]       w_add_a;
    logic [W-1:0]       w_add_b;
    logic               w_add_cin;
    logic [W-1:0]       w_add_s;
    logic               w_add_cout;

    // Unpack operands and build the round-robin search order starting at
    // r_rr_ptr: w_cand[k] is the k-th requester examined.
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_req
            assign w_a_arr[i] = req_a[i*2*W +: 2*W];
            assign w_b_arr[i] = req_b[i*2*W +: 2*W];
            assign w_cand[i]  = ID_W'((int'(r_rr_ptr) + i) % NREQ);
        end
    endgenerate

    // Walk the search order backwards so the earliest valid candidate wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[w_cand[k]]) begin
                w_found = 1'b1;
                w_gnt   = w_cand[k];
            end
        end
    end

    assign w_accept = (r_state == ST_IDLE) && w_found;

    // Grant is combinational, but suppressed while reset is held so no
    // requester sees an acceptance that the FSM will not act on.
    always_comb begin
        req_ready = '0;
        if (w_accept && !rst) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    // Operand muxes for the shared adder: low slice with cin=sub in LO,
    // high slice with the registered low carry in HI.
    assign w_hi      = (r_state == ST_HI);
    assign w_add_a   = w_hi ? r_a[2*W-1:W] : r_a[W-1:0];
    assign w_add_b   = w_hi ? r_b[2*W-1:W] : r_b[W-1:0];
    assign w_add_cin = w_hi ? r_c_lo       : r_sub;

    fulladder32 #(
        .W    (W)
    ) u_adder (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (w_add_cin),
        .s    (w_add_s),
        .cout (w_add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_sub     <= 1'b0;
            r_wide    <= 1'b0;
            r_s_lo    <= '0;
            r_c_lo    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_s     <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a    <= w_a_arr[w_gnt];
                        r_b    <= w_b_arr[w_gnt] ^ {(2*W){req_sub[w_gnt]}};
                        r_sub  <= req_sub[w_gnt];
                        r_wide <= req_wide[w_gnt];
                        r_gnt  <= w_gnt;
                        r_state <= ST_LO;
                    end
                end
                ST_LO: begin
                    r_s_lo <= w_add_s;
                    r_c_lo <= w_add_cout;
                    if (r_wide) begin
                        r_state <= ST_HI;
                    end else begin
                        rsp_s     <= {{W{1'b0}}, w_add_s};
                        rsp_cout  <= w_add_cout;
                        rsp_ovf   <= signed_ovf(r_a[W-1], r_b[W-1], w_add_s[W-1]);
                        rsp_id    <= r_gnt;
                        rsp_valid <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_HI: begin
                    rsp_s     <= {w_add_s, r_s_lo};
                    rsp_cout  <= w_add_cout;
                    rsp_ovf   <= signed_ovf(r_a[2*W-1], r_b[2*W-1], w_add_s[W-1]);
                    rsp_id    <= r_gnt;
                    rsp_valid <= 1'b1;
                    r_state   <= ST_RESP;
                end
                ST_RESP: begin
                    // Result registers hold their value while stalled.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_rr_ptr  <= (r_gnt == ID_W'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
